pot_adc_reader: RTL and testbench



---
 rtl/pot_adc_reader_if.sv | 39 +++
 rtl/pot_adc_reader.sv | 150 +++++++++++++++
 tb/tb_pot_adc_reader.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pot_adc_reader_if.sv
// ============================================================================
// Module      : pot_adc_reader_if
// Description : SPI pins of the pot ADC plus the pot code handed to the scaler.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface pot_adc_reader_if;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [11:0] pot;
    logic        pot_vld;
    logic        busy;

    modport master (
        output SS_n,
        output SCLK,
        output MOSI,
        input  MISO,
        output pot,
        output pot_vld,
        output busy
    );

    modport slave (
        input  SS_n,
        input  SCLK,
        input  MOSI,
        output MISO,
        input  pot,
        input  pot_vld,
        input  busy
    );
endinterface

`default_nettype wire

// File: rtl/pot_adc_reader.sv
// ============================================================================
// Module      : pot_adc_reader
// Description : Periodic SPI conversion of the volume pot with slew-limited output.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pot_adc_reader #(
    parameter int unsigned SCLK_DIV  = 32,
    parameter logic [2:0]  CHANNEL   = 3'd1,
    parameter logic [19:0] PERIOD    = 20'd50000,
    parameter logic [11:0] SLEW_STEP = 12'd16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    pot_adc_reader_if.master  bus
);

    localparam int unsigned         C_HALF    = SCLK_DIV / 2;
    localparam int                  DIV_W     = (C_HALF > 1) ? $clog2(C_HALF) : 1;
    localparam logic [DIV_W-1:0]    C_HALF_M1 = DIV_W'(C_HALF - 1);
    localparam logic [15:0]         C_CMD     = {2'b00, CHANNEL, 11'b0};
    localparam logic [20:0]         C_PERIOD  = {1'b0, PERIOD};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FRONT = 3'd1,
        S_SHIFT = 3'd2,
        S_BACK  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    logic [DIV_W-1:0]   r_div;
    logic [3:0]         r_rises;
    logic               r_sclk;
    logic               r_ss_n;
    logic               r_busy;
    logic [15:0]        r_mosi_sr;
    // Only the low 12 bits of the 16-bit frame matter, so older bits fall off the top.
    logic [11:0]        r_shift;
    logic [19:0]        r_cnt;
    logic               r_primer;
    logic [11:0]        r_pot;
    logic               r_vld;

    logic               w_expired;
    logic               w_up;
    logic [11:0]        w_diff;
    logic [11:0]        w_next;

    assign w_expired = ({1'b0, r_cnt} + 21'd1) >= C_PERIOD;
    assign w_up      = r_shift >= r_pot;
    assign w_diff    = w_up ? (r_shift - r_pot) : (r_pot - r_shift);
    // Ordered subtraction keeps the step inside 0..4095 without any wrap.
    assign w_next    = (w_diff <= SLEW_STEP) ? r_shift :
                       w_up ? (r_pot + SLEW_STEP) : (r_pot - SLEW_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_rises   <= '0;
            r_sclk    <= 1'b1;
            r_ss_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_mosi_sr <= '0;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_primer  <= 1'b1;
            r_pot     <= '0;
            r_vld     <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            if (r_cnt != '1) r_cnt <= r_cnt + 20'd1;

            case (r_state)
                S_IDLE: begin
                    if (r_primer || w_expired) begin
                        r_state   <= S_FRONT;
                        r_ss_n    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_mosi_sr <= C_CMD;
                        r_div     <= '0;
                        r_rises   <= '0;
                        r_cnt     <= '0;
                    end
                end
                S_FRONT: begin
                    if (r_div == C_HALF_M1) begin
                        r_div   <= '0;
                        r_sclk  <= 1'b0;
                        r_state <= S_SHIFT;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (r_div == C_HALF_M1) begin
                        r_div <= '0;
                        if (!r_sclk) begin
                            r_sclk  <= 1'b1;
                            r_shift <= {r_shift[10:0], bus.MISO};
                            r_rises <= r_rises + 4'd1;
                            if (r_rises == 4'd15) r_state <= S_BACK;
                        end else begin
                            // The first fall happens in FRONT, so every fall here advances MOSI.
                            r_sclk    <= 1'b0;
                            r_mosi_sr <= {r_mosi_sr[14:0], 1'b0};
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_BACK: begin
                    if (r_div == C_HALF_M1) begin
                        r_div   <= '0;
                        r_ss_n  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_DONE: begin
                    // The ADC answers with the previous channel, so the first frame is stale.
                    if (r_primer) begin
                        r_primer <= 1'b0;
                    end else begin
                        r_pot <= w_next;
                        r_vld <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.SS_n    = r_ss_n;
    assign bus.SCLK    = r_sclk;
    assign bus.MOSI    = r_mosi_sr[15];
    assign bus.pot     = r_pot;
    assign bus.pot_vld = r_vld;
    assign bus.busy    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_pot_adc_reader.sv
// ============================================================================
// Module      : tb_pot_adc_reader
// Description : Scoreboard bench for pot_adc_reader with two ADC models.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pot_adc_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0_n = 1'b0;
    logic rst1_n = 1'b0;

    pot_adc_reader_if ifc0 ();
    pot_adc_reader_if ifc1 ();

    // dut0: unlimited slew, 2000-clk period; dut1: 16-code slew, back-to-back frames
    pot_adc_reader #(
        .SCLK_DIV  (32),
        .CHANNEL   (3'd1),
        .PERIOD    (20'd2000),
        .SLEW_STEP (12'd4095)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst0_n),
        .bus   (ifc0.master)
    );

    pot_adc_reader #(
        .SCLK_DIV  (32),
        .CHANNEL   (3'd1),
        .PERIOD    (20'd10),
        .SLEW_STEP (12'd16)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst1_n),
        .bus   (ifc1.master)
    );

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_run++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // ADC models: bit 15 of the frame goes out on the first SCLK fall, MISO idles high.
    logic [11:0] val0 = 12'hABC;
    logic [11:0] val1 = 12'h100;
    logic [15:0] frame0, frame1;
    logic        m0_bit = 1'b1, m1_bit = 1'b1;
    int          m0_idx = 15, m1_idx = 15;

    assign frame0 = {4'b0101, val0};
    assign frame1 = {4'b1010, val1};
    assign ifc0.MISO = ifc0.SS_n ? 1'b1 : m0_bit;
    assign ifc1.MISO = ifc1.SS_n ? 1'b1 : m1_bit;

    always @(negedge ifc0.SCLK or negedge ifc0.SS_n) begin
        if (ifc0.SCLK) m0_idx = 15;
        else if (m0_idx >= 0) begin m0_bit = frame0[m0_idx]; m0_idx--; end
    end

    always @(negedge ifc1.SCLK or negedge ifc1.SS_n) begin
        if (ifc1.SCLK) m1_idx = 15;
        else if (m1_idx >= 0) begin m1_bit = frame1[m1_idx]; m1_idx--; end
    end

    logic [11:0] q0[$];
    logic [11:0] q1[$];
    int          vld0_cnt = 0;
    int          hold_err = 0;
    logic [11:0] last1    = 12'h000;

    always @(negedge clk) begin
        if (rst0_n === 1'b1 && ifc0.pot_vld === 1'b1) begin
            vld0_cnt++;
            if (q0.size() == 0) begin
                n_run++; n_fail++;
                $display("FAIL sb0_unexpected_vld: pot=0x%0h, expected no update", ifc0.pot);
            end else chk("sb0_pot", 32'(ifc0.pot), 32'(q0.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (rst1_n === 1'b1 && ifc1.pot_vld === 1'b1) begin
            if (q1.size() == 0) begin
                n_run++; n_fail++;
                $display("FAIL sb1_unexpected_vld: pot=0x%0h, expected no update", ifc1.pot);
            end else chk("sb1_pot", 32'(ifc1.pot), 32'(q1.pop_front()));
        end
        if (rst1_n === 1'b1 && ifc1.pot_vld !== 1'b1 && ifc1.pot !== last1) hold_err++;
        last1 = ifc1.pot;
    end

    task automatic run0();
        int          cyc, low, rises, busy_err, since;
        logic [15:0] mosi;
        logic        prev_sclk;
        rst0_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ss_n",    32'(ifc0.SS_n),    1);
        chk("rst_sclk",    32'(ifc0.SCLK),    1);
        chk("rst_mosi",    32'(ifc0.MOSI),    0);
        chk("rst_pot",     32'(ifc0.pot),     0);
        chk("rst_pot_vld", 32'(ifc0.pot_vld), 0);
        chk("rst_busy",    32'(ifc0.busy),    0);
        rst0_n = 1'b1;
        cyc = 0;
        while (ifc0.SS_n === 1'b1 && cyc < 4) begin @(negedge clk); cyc++; end
        chk("rst_to_ss_fall_clks", cyc, 1);

        low = 1; since = 0; rises = 0; mosi = '0; busy_err = 0; prev_sclk = ifc0.SCLK;
        while (ifc0.SS_n === 1'b0 && low < 1000) begin
            @(negedge clk);
            since++;
            if (ifc0.busy !== ~ifc0.SS_n) busy_err++;
            if (ifc0.SS_n === 1'b0) low++;
            if (ifc0.SCLK === 1'b1 && prev_sclk === 1'b0) begin
                rises++;
                mosi = {mosi[14:0], ifc0.MOSI};
            end
            prev_sclk = ifc0.SCLK;
        end
        chk("ss_low_clks",   low,      528);
        chk("sclk_rises",    rises,    16);
        chk("mosi_cmd",      mosi,     32'h0800);
        chk("busy_tracking", busy_err, 0);

        while (ifc0.SS_n === 1'b1 && since < 3000) begin @(negedge clk); since++; end
        chk("period_2000",     since,        2000);
        chk("primer_pot",      32'(ifc0.pot), 0);
        chk("primer_no_vld",   vld0_cnt,     0);
        q0.push_back(12'hABC);

        cyc = 0;
        while (ifc0.SS_n === 1'b0 && cyc < 1000) begin @(negedge clk); cyc++; end
        repeat (3) @(negedge clk);
        chk("frame2_pot",      32'(ifc0.pot), 32'hABC);
        chk("frame2_vld_once", vld0_cnt,     1);

        cyc = 0;
        while (ifc0.SS_n === 1'b1 && cyc < 3000) begin @(negedge clk); cyc++; end
        chk("frame3_start", 32'(ifc0.SS_n), 0);
        rises = 0; cyc = 0; prev_sclk = ifc0.SCLK;
        while (rises < 8 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (ifc0.SCLK === 1'b1 && prev_sclk === 1'b0) rises++;
            prev_sclk = ifc0.SCLK;
        end
        chk("midframe_rises", rises, 8);
        rst0_n = 1'b0;
        #1;
        chk("abort_ss_n", 32'(ifc0.SS_n), 1);
        chk("abort_sclk", 32'(ifc0.SCLK), 1);
        chk("abort_pot",  32'(ifc0.pot),  0);
        chk("abort_busy", 32'(ifc0.busy), 0);
        repeat (3) @(negedge clk);
        rst0_n = 1'b1;
        cyc = 0;
        while (ifc0.SS_n === 1'b1 && cyc < 4) begin @(negedge clk); cyc++; end
        chk("rearm_ss_fall_clks", cyc, 1);
        cyc = 0;
        while (ifc0.SS_n === 1'b0 && cyc < 1000) begin @(negedge clk); cyc++; end
        repeat (5) @(negedge clk);
        chk("rearm_primer_pot", 32'(ifc0.pot), 0);
        chk("rearm_primer_vld", vld0_cnt,     1);
        rst0_n = 1'b0;
    endtask

    task automatic run1();
        int   cyc, req;
        bit   found;
        logic prev_ss;
        rst1_n = 1'b0;
        val1   = 12'h100;
        repeat (3) @(negedge clk);
        chk("rst1_pot", 32'(ifc1.pot), 0);
        rst1_n  = 1'b1;
        prev_ss = 1'b1;
        for (int f = 0; f < 36; f++) begin
            cyc = 0; found = 1'b0;
            while (!found && cyc < 2000) begin
                @(negedge clk);
                cyc++;
                if (ifc1.SS_n === 1'b0 && prev_ss === 1'b1) found = 1'b1;
                prev_ss = ifc1.SS_n;
            end
            if (!found) begin
                chk("dut1_frame_start", 32'(found), 1);
                break;
            end
            if (f == 2 || f == 20) chk("period_back_to_back", cyc, 530);
            // Ramp up to 0x100, step 8 down to 0xF8, then ramp down to 0.
            if (f <= 17)      val1 = 12'h100;
            else if (f == 18) val1 = 12'h0F8;
            else              val1 = 12'h000;
            if (f >= 1) begin
                if (f <= 16)      req = 16 * f;
                else if (f == 17) req = 'h100;
                else if (f == 18) req = 'h0F8;
                else if (f <= 33) req = 'h0E8 - 16 * (f - 19);
                else              req = 0;
                q1.push_back(12'(req));
            end
        end
        cyc = 0;
        while (q1.size() != 0 && cyc < 1000) begin @(negedge clk); cyc++; end
        chk("sb1_drained",          q1.size(),    0);
        chk("final_pot",            32'(ifc1.pot), 0);
        chk("pot_hold_between_vld", hold_err,     0);
        rst1_n = 1'b0;
    endtask

    initial begin
        fork
            run0();
            run1();
        join
        repeat (5) @(negedge clk);
        chk("sb0_drained", q0.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, expected bench to finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
